// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer (fetch_ctl)
// and its optional fetch watchdog.
package fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_WAIT   = 3'd2,
        ST_ISSUE  = 3'd3,
        ST_UPDATE = 3'd4,
        ST_HALT   = 3'd5,
        ST_FAULT  = 3'd6
    } fetch_state_t;

    localparam int unsigned PC_INC                = 4;
    localparam int unsigned FETCH_TIMEOUT_DEFAULT = 255;

    localparam logic PC_CTL_INC = 1'b0;
    localparam logic PC_CTL_ADD = 1'b1;

    // Branch targets must stay on 4-byte instruction boundaries.
    function automatic logic word_aligned(input logic [1:0] low_bits);
        return low_bits == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_watchdog.sv
// Counts consecutive cycles spent waiting on instruction memory and flags
// the cycle in which the wait budget is used up.
module fetch_watchdog
    import fetch_pkg::*;
#(
    parameter int unsigned TIMEOUT = FETCH_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic clear,
    output logic expired
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    // count holds the number of waiting cycles already completed, so the
    // TIMEOUT-th waiting cycle is the one that sees count == TIMEOUT-1.
    logic [CNT_W-1:0] count;

    assign expired = start && (count == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (start && !expired) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fetch_ctl.sv
// Instruction-fetch sequencer: fetches at pc, hands the word to decode, then steps pc.
// Define FETCH_CTL_TIMEOUT_EN to fault when instruction memory never acknowledges.
module fetch_ctl
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
`ifdef FETCH_CTL_TIMEOUT_EN
    ,
    parameter int unsigned FETCH_TIMEOUT = FETCH_TIMEOUT_DEFAULT
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [ADDR_W-1:0] pc_addr,
    output logic              pc_oe,
    output logic              pc_ctl,
    output logic [ADDR_W-1:0] pc_offset,
    output logic              step_pc,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [ADDR_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] ir,
    output logic              ir_valid,
    input  logic              ir_ready,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_offset,
    output logic              halted,
    output logic              fault,
    output fetch_state_t      state
);

    // Handshakes: a transfer happens on a rising edge where both sides are
    // high (mem_req/mem_ack, ir_valid/ir_ready); the initiator holds its
    // request and payload stable until then and drops it the cycle after.

    fetch_state_t state_q, state_d;

    logic              pc_oe_d, pc_ctl_d, step_pc_d, mem_req_d;
    logic              ir_valid_d, halted_d, fault_d;
    logic [ADDR_W-1:0] pc_offset_d, mem_addr_d, ir_d;

    logic ir_handshake;
    logic misaligned;
    logic self_loop;
    logic timeout_hit;

    assign ir_handshake = (state_q == ST_ISSUE) && ir_ready;
    assign misaligned   = br_taken && !word_aligned(br_offset[1:0]);
    // A taken branch of zero would refetch the same word forever.
    assign self_loop    = (pc_ctl == PC_CTL_ADD) && (pc_offset == '0);

`ifdef FETCH_CTL_TIMEOUT_EN
    fetch_watchdog #(
        .TIMEOUT (FETCH_TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .start   (state_q == ST_WAIT),
        .clear   (state_q == ST_ADDR),
        .expired (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pc_oe     <= 1'b0;
            pc_ctl    <= PC_CTL_INC;
            pc_offset <= '0;
            step_pc   <= 1'b0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            ir        <= '0;
            ir_valid  <= 1'b0;
            halted    <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_oe     <= pc_oe_d;
            pc_ctl    <= pc_ctl_d;
            pc_offset <= pc_offset_d;
            step_pc   <= step_pc_d;
            mem_req   <= mem_req_d;
            mem_addr  <= mem_addr_d;
            ir        <= ir_d;
            ir_valid  <= ir_valid_d;
            halted    <= halted_d;
            fault     <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (run) state_d = ST_ADDR;
            ST_ADDR:   state_d = ST_WAIT;
            ST_WAIT: begin
                // An ack in the same cycle as the timeout still completes the fetch.
                if (mem_ack)          state_d = ST_ISSUE;
                else if (timeout_hit) state_d = ST_FAULT;
            end
            ST_ISSUE: begin
                if (ir_handshake) state_d = misaligned ? ST_FAULT : ST_UPDATE;
            end
            ST_UPDATE: begin
                if (self_loop) state_d = ST_HALT;
                else if (run)  state_d = ST_ADDR;
                else           state_d = ST_IDLE;
            end
            ST_HALT:   state_d = ST_HALT;
            ST_FAULT:  state_d = ST_FAULT;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Every output is a register whose next value follows the state being entered.
    always_comb begin
        pc_oe_d     = (state_d == ST_ADDR);
        mem_req_d   = (state_d == ST_WAIT);
        ir_valid_d  = (state_d == ST_ISSUE);
        step_pc_d   = (state_d == ST_UPDATE);
        halted_d    = (state_d == ST_HALT);
        fault_d     = (state_d == ST_FAULT);

        mem_addr_d  = mem_addr;
        ir_d        = ir;
        pc_ctl_d    = pc_ctl;
        pc_offset_d = pc_offset;

        if (state_q == ST_ADDR) begin
            mem_addr_d = pc_addr;
        end
        if ((state_q == ST_WAIT) && mem_ack) begin
            ir_d = mem_rdata;
        end
        if (ir_handshake && !misaligned) begin
            if (br_taken) begin
                pc_ctl_d    = PC_CTL_ADD;
                pc_offset_d = br_offset;
            end else begin
                pc_ctl_d    = PC_CTL_INC;
                pc_offset_d = '0;
            end
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_fetch_ctl.sv
// Directed testbench for fetch_ctl with a behavioural pc, memory responder and decoder.
`timescale 1ns/1ps
module tb_fetch_ctl;
  import fetch_pkg::*;

  localparam int W          = 32;
  localparam int WAIT_LIMIT = 40;

  logic         clk = 1'b0;
  logic         rst;
  logic         run;
  logic [W-1:0] pc_addr;
  logic         pc_oe, pc_ctl, step_pc, mem_req, ir_valid, halted, fault;
  logic [W-1:0] pc_offset, mem_addr, ir;
  logic         mem_ack, ir_ready, br_taken;
  logic [W-1:0] mem_rdata, br_offset;
  fetch_state_t state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 400us");
    $fatal(1);
  end

  fetch_ctl #(
    .ADDR_W(W)
`ifdef FETCH_CTL_TIMEOUT_EN
    , .FETCH_TIMEOUT(8)
`endif
  ) dut (
    .clk(clk), .rst(rst), .run(run), .pc_addr(pc_addr),
    .pc_oe(pc_oe), .pc_ctl(pc_ctl), .pc_offset(pc_offset), .step_pc(step_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ir(ir), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .br_taken(br_taken), .br_offset(br_offset),
    .halted(halted), .fault(fault), .state(state)
  );

  // ---------------- pc model ----------------
  logic         pc_load = 1'b0;
  logic [W-1:0] pc_load_val = '0;

  always @(posedge clk) begin
    if (pc_load) pc_addr <= pc_load_val;
    else if (step_pc) pc_addr <= (pc_ctl == PC_CTL_ADD) ? pc_addr + pc_offset : pc_addr + W'(PC_INC);
  end

  // ---------------- passive monitor ----------------
  int unsigned cyc = 0;
  int unsigned req_cnt = 0;
  int unsigned step_consec = 0;
  logic        step_prev = 1'b0;
  int          step_cyc_q[$];
  logic        step_ctl_q[$];

  initial forever begin
    @(posedge clk);
    cyc++;
    if (mem_req === 1'b1) req_cnt++;
    if (step_pc === 1'b1) begin
      step_cyc_q.push_back(int'(cyc));
      step_ctl_q.push_back(pc_ctl);
      if (step_prev) step_consec++;
    end
    step_prev = (step_pc === 1'b1);
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    ir_ready = 1'b0; br_taken = 1'b0; br_offset = '0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic load_pc(input logic [W-1:0] val);
    pc_load = 1'b1; pc_load_val = val;
    tick();
    pc_load = 1'b0;
  endtask

  task automatic serve_fetch(input int ack_delay, input logic [W-1:0] word,
                             output logic [W-1:0] addr, output bit seen, output bit held);
    int waited = 0;
    seen = 1'b0; held = 1'b1; addr = '0;
    while (mem_req !== 1'b1 && waited < WAIT_LIMIT) begin
      tick();
      waited++;
    end
    if (mem_req !== 1'b1) return;
    seen = 1'b1;
    addr = mem_addr;
    for (int i = 0; i < ack_delay; i++) begin
      tick();
      if (mem_req !== 1'b1 || mem_addr !== addr) held = 1'b0;
    end
    mem_ack = 1'b1; mem_rdata = word;
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
  endtask

  task automatic accept_ir(input int ready_delay, input logic take, input logic [W-1:0] off,
                           output logic [W-1:0] word, output bit seen, output bit held);
    int waited = 0;
    seen = 1'b0; held = 1'b1; word = '0;
    while (ir_valid !== 1'b1 && waited < WAIT_LIMIT) begin
      tick();
      waited++;
    end
    if (ir_valid !== 1'b1) return;
    seen = 1'b1;
    word = ir;
    for (int i = 0; i < ready_delay; i++) begin
      tick();
      if (ir_valid !== 1'b1 || ir !== word) held = 1'b0;
    end
    ir_ready = 1'b1; br_taken = take; br_offset = off;
    tick();
    ir_ready = 1'b0; br_taken = 1'b0; br_offset = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; run = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    ir_ready = 1'b0; br_taken = 1'b0; br_offset = '0;
    tick(2);
    n_checks++;
    if ({pc_oe, pc_ctl, step_pc, mem_req, ir_valid, halted, fault} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b required 0000000",
               {pc_oe, pc_ctl, step_pc, mem_req, ir_valid, halted, fault});
    end
    n_checks++;
    if (pc_offset !== '0 || mem_addr !== '0 || ir !== '0 || state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL reset_values: off=%h addr=%h ir=%h state=%0d required all 0 / IDLE",
               pc_offset, mem_addr, ir, state);
    end
    rst = 1'b0;
    // An ack while idle must not load ir or start anything.
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    tick();
    n_checks++;
    if (ir !== '0 || state !== ST_IDLE || mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL spurious_ack: ir=%h state=%0d req=%b required 0/IDLE/0", ir, state, mem_req);
    end
  endtask

  task automatic test_sequential();
    logic [W-1:0] addr, word, e;
    bit seen, held, seen2, held2;
    int base;
    do_reset();
    load_pc(32'h0);
    base = step_cyc_q.size();
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    run = 1'b1;
    tick();
    n_checks++;
    if (pc_oe !== 1'b1 || state !== ST_ADDR) begin
      n_fail++;
      $display("FAIL seq_addr_phase: pc_oe=%b state=%0d required 1/ADDR", pc_oe, state);
    end
    for (int i = 0; i < 3; i++) begin
      serve_fetch(0, 32'h1000_0000 + W'(i), addr, seen, held);
      e = exp_q.pop_front();
      n_checks++;
      if (!seen || addr !== e) begin
        n_fail++;
        $display("FAIL seq_mem_addr[%0d]: got %h (seen=%0d) required %h", i, addr, seen, e);
      end
      accept_ir(0, 1'b0, '0, word, seen2, held2);
      n_checks++;
      if (!seen2 || word !== 32'h1000_0000 + W'(i)) begin
        n_fail++;
        $display("FAIL seq_ir[%0d]: got %h required %h", i, word, 32'h1000_0000 + W'(i));
      end
    end
    run = 1'b0;
    tick(2);
    n_checks++;
    if (step_cyc_q.size() - base !== 3) begin
      n_fail++;
      $display("FAIL seq_step_count: got %0d required 3", step_cyc_q.size() - base);
    end else begin
      n_checks++;
      if (step_cyc_q[base+1] - step_cyc_q[base] !== 4 || step_cyc_q[base+2] - step_cyc_q[base+1] !== 4) begin
        n_fail++;
        $display("FAIL seq_step_spacing: got %0d,%0d required 4,4",
                 step_cyc_q[base+1] - step_cyc_q[base], step_cyc_q[base+2] - step_cyc_q[base+1]);
      end
      n_checks++;
      if ({step_ctl_q[base], step_ctl_q[base+1], step_ctl_q[base+2]} !== 3'b000) begin
        n_fail++;
        $display("FAIL seq_pc_ctl: got %b required 000",
                 {step_ctl_q[base], step_ctl_q[base+1], step_ctl_q[base+2]});
      end
    end
  endtask

  task automatic test_branch();
    logic [W-1:0] addr, word;
    bit seen, held, seen2, held2;
    do_reset();
    load_pc(32'h10);
    run = 1'b1;
    serve_fetch(0, 32'hB000_0001, addr, seen, held);
    n_checks++;
    if (!seen || addr !== 32'h10) begin
      n_fail++;
      $display("FAIL br_first_addr: got %h required 00000010", addr);
    end
    accept_ir(0, 1'b1, 32'hFFFF_FFF8, word, seen2, held2);
    n_checks++;
    if (step_pc !== 1'b1 || pc_ctl !== 1'b1 || pc_offset !== 32'hFFFF_FFF8) begin
      n_fail++;
      $display("FAIL br_update: step=%b ctl=%b off=%h required 1/1/fffffff8", step_pc, pc_ctl, pc_offset);
    end
    tick();
    n_checks++;
    if (pc_ctl !== 1'b1 || pc_offset !== 32'hFFFF_FFF8 || step_pc !== 1'b0) begin
      n_fail++;
      $display("FAIL br_hold_after_update: step=%b ctl=%b off=%h required 0/1/fffffff8",
               step_pc, pc_ctl, pc_offset);
    end
    serve_fetch(0, 32'hB000_0002, addr, seen, held);
    n_checks++;
    if (!seen || addr !== 32'h8) begin
      n_fail++;
      $display("FAIL br_target_addr: got %h required 00000008", addr);
    end
    accept_ir(0, 1'b0, 32'h0000_0010, word, seen2, held2);
    run = 1'b0;
    n_checks++;
    if (step_pc !== 1'b1 || pc_ctl !== 1'b0 || pc_offset !== '0) begin
      n_fail++;
      $display("FAIL br_seq_after: step=%b ctl=%b off=%h required 1/0/0", step_pc, pc_ctl, pc_offset);
    end
    tick(2);
  endtask

  task automatic test_misaligned();
    logic [W-1:0] addr, word;
    bit seen, held, seen2, held2;
    int base_step;
    int unsigned base_req;
    do_reset();
    load_pc(32'h20);
    run = 1'b1;
    base_step = step_cyc_q.size();
    serve_fetch(0, 32'hC000_0001, addr, seen, held);
    n_checks++;
    if (!seen || addr !== 32'h20) begin
      n_fail++;
      $display("FAIL mis_addr: got %h required 00000020", addr);
    end
    accept_ir(0, 1'b1, 32'h6, word, seen2, held2);
    base_req = req_cnt;
    n_checks++;
    if (fault !== 1'b1 || state !== ST_FAULT || step_pc !== 1'b0) begin
      n_fail++;
      $display("FAIL mis_fault: fault=%b state=%0d step=%b required 1/FAULT/0", fault, state, step_pc);
    end
    tick(6);
    n_checks++;
    if (fault !== 1'b1 || req_cnt !== base_req || step_cyc_q.size() !== base_step || mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL mis_sticky: fault=%b new_req=%0d new_steps=%0d required 1/0/0",
               fault, req_cnt - base_req, step_cyc_q.size() - base_step);
    end
    do_reset();
    n_checks++;
    if (fault !== 1'b0 || state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL mis_clear: fault=%b state=%0d required 0/IDLE", fault, state);
    end
  endtask

  task automatic test_self_loop();
    logic [W-1:0] addr, word;
    bit seen, held, seen2, held2;
    int base_step;
    int unsigned base_req;
    do_reset();
    load_pc(32'h40);
    run = 1'b1;
    base_step = step_cyc_q.size();
    serve_fetch(0, 32'hD000_0001, addr, seen, held);
    accept_ir(0, 1'b1, 32'h0, word, seen2, held2);
    n_checks++;
    if (step_pc !== 1'b1 || halted !== 1'b0) begin
      n_fail++;
      $display("FAIL loop_update: step=%b halted=%b required 1/0", step_pc, halted);
    end
    base_req = req_cnt;
    tick();
    n_checks++;
    if (halted !== 1'b1 || state !== ST_HALT) begin
      n_fail++;
      $display("FAIL loop_halt: halted=%b state=%0d required 1/HALT", halted, state);
    end
    tick(6);
    n_checks++;
    if (halted !== 1'b1 || req_cnt !== base_req || step_cyc_q.size() - base_step !== 1 || pc_addr !== 32'h40) begin
      n_fail++;
      $display("FAIL loop_sticky: halted=%b new_req=%0d steps=%0d pc=%h required 1/0/1/00000040",
               halted, req_cnt - base_req, step_cyc_q.size() - base_step, pc_addr);
    end
    run = 1'b0;
  endtask

  task automatic test_run_drop();
    logic [W-1:0] addr, word;
    bit seen, held, seen2, held2;
    int base_step;
    int unsigned base_req;
    do_reset();
    load_pc(32'h30);
    run = 1'b1;
    base_step = step_cyc_q.size();
    tick(2);
    n_checks++;
    if (mem_req !== 1'b1 || state !== ST_WAIT) begin
      n_fail++;
      $display("FAIL drop_in_wait: req=%b state=%0d required 1/WAIT", mem_req, state);
    end
    run = 1'b0;
    serve_fetch(5, 32'hE000_0001, addr, seen, held);
    n_checks++;
    if (!seen || !held || addr !== 32'h30) begin
      n_fail++;
      $display("FAIL drop_wait_hold: addr=%h held=%0d required 00000030/1", addr, held);
    end
    accept_ir(0, 1'b0, '0, word, seen2, held2);
    n_checks++;
    if (!seen2 || word !== 32'hE000_0001 || step_pc !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_issue: ir=%h step=%b required e0000001/1", word, step_pc);
    end
    base_req = req_cnt;
    tick(4);
    n_checks++;
    if (state !== ST_IDLE || req_cnt !== base_req || step_cyc_q.size() - base_step !== 1) begin
      n_fail++;
      $display("FAIL drop_idle: state=%0d new_req=%0d steps=%0d required IDLE/0/1",
               state, req_cnt - base_req, step_cyc_q.size() - base_step);
    end
    run = 1'b1;
    serve_fetch(0, 32'hE000_0002, addr, seen, held);
    n_checks++;
    if (!seen || addr !== 32'h34) begin
      n_fail++;
      $display("FAIL drop_resume_addr: got %h required 00000034", addr);
    end
    accept_ir(0, 1'b0, '0, word, seen2, held2);
    run = 1'b0;
    tick(2);
  endtask

  task automatic test_stall();
    logic [W-1:0] addr, word;
    bit seen, held, seen2, held2;
    do_reset();
    load_pc(32'h50);
    run = 1'b1;
    serve_fetch(2, 32'hF000_0005, addr, seen, held);
    n_checks++;
    if (!seen || !held || addr !== 32'h50) begin
      n_fail++;
      $display("FAIL stall_fetch: addr=%h held=%0d required 00000050/1", addr, held);
    end
    run = 1'b0;
    accept_ir(3, 1'b0, '0, word, seen2, held2);
    n_checks++;
    if (!seen2 || !held2 || word !== 32'hF000_0005) begin
      n_fail++;
      $display("FAIL stall_issue: ir=%h held=%0d required f0000005/1", word, held2);
    end
    tick();
    n_checks++;
    if (ir_valid !== 1'b0 || state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL stall_valid_drop: ir_valid=%b state=%0d required 0/IDLE", ir_valid, state);
    end
  endtask

  task automatic test_rst_in_wait();
    do_reset();
    load_pc(32'h60);
    run = 1'b1;
    tick(2);
    rst = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hABCD_0123;
    tick();
    rst = 1'b0; mem_ack = 1'b0; mem_rdata = '0; run = 1'b0;
    n_checks++;
    if ({pc_oe, pc_ctl, step_pc, mem_req, ir_valid, halted, fault} !== 7'b0 || state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL rst_wait_flags: got %b state=%0d required 0000000/IDLE",
               {pc_oe, pc_ctl, step_pc, mem_req, ir_valid, halted, fault}, state);
    end
    n_checks++;
    if (mem_addr !== '0 || ir !== '0 || pc_offset !== '0) begin
      n_fail++;
      $display("FAIL rst_wait_values: addr=%h ir=%h off=%h required 0/0/0", mem_addr, ir, pc_offset);
    end
  endtask

`ifdef FETCH_CTL_TIMEOUT_EN
  task automatic test_timeout();
    int n = 0;
    int waited = 0;
    do_reset();
    load_pc(32'h70);
    run = 1'b1;
    while (mem_req !== 1'b1 && waited < WAIT_LIMIT) begin
      tick();
      waited++;
    end
    while (mem_req === 1'b1 && n < 50) begin
      n++;
      tick();
    end
    n_checks++;
    if (n !== 8 || fault !== 1'b1 || state !== ST_FAULT) begin
      n_fail++;
      $display("FAIL timeout_fault: wait_cycles=%0d fault=%b state=%0d required 8/1/FAULT", n, fault, state);
    end
    run = 1'b0;
  endtask

  task automatic test_ack_at_timeout();
    logic [W-1:0] word;
    bit seen2, held2;
    int waited = 0;
    do_reset();
    load_pc(32'h80);
    run = 1'b1;
    while (mem_req !== 1'b1 && waited < WAIT_LIMIT) begin
      tick();
      waited++;
    end
    tick(7);
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    mem_ack = 1'b0; mem_rdata = '0; run = 1'b0;
    n_checks++;
    if (fault !== 1'b0 || state !== ST_ISSUE || ir !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL timeout_ack_wins: fault=%b state=%0d ir=%h required 0/ISSUE/12345678", fault, state, ir);
    end
    accept_ir(0, 1'b0, '0, word, seen2, held2);
    tick(2);
  endtask
`endif

  task automatic test_step_spacing();
    n_checks++;
    if (step_consec !== 0) begin
      n_fail++;
      $display("FAIL step_never_consecutive: got %0d back-to-back pulses required 0", step_consec);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_misaligned();
    test_self_loop();
    test_run_drop();
    test_stall();
    test_rst_in_wait();
`ifdef FETCH_CTL_TIMEOUT_EN
    test_timeout();
    test_ack_at_timeout();
`endif
    test_step_spacing();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
